// File: rtl/uart_tx_fifo_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_mmio_if
// Description : Core load/store bus plus serialiser valid/ready handshake
//               for the memory-mapped UART transmit front-end.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_mmio_if #(
   parameter int DATA_W = 64
);
   logic [63:0]       address;
   logic              i_wen;
   logic              i_ren;
   logic [DATA_W-1:0] i_data;
   logic [DATA_W-1:0] o_rdata;
   logic              stall;
   logic [7:0]        uart_out_data;
   logic              valid;
   logic              ready;

   modport master (
      output address, i_wen, i_ren, i_data, ready,
      input  o_rdata, stall, uart_out_data, valid
   );

   modport slave (
      input  address, i_wen, i_ren, i_data, ready,
      output o_rdata, stall, uart_out_data, valid
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_mmio
// Description : MMIO UART transmit front-end: show-ahead byte FIFO drained
//               over valid/ready, with STATUS and CTRL (flush, tx gate) regs.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_mmio #(
   parameter logic [63:0] BASE_ADDR = 64'h1000_0000,
   parameter int          DEPTH     = 16,
   parameter int          DATA_W    = 64
) (
   input wire                 clk,
   input wire                 rst,
   uart_tx_fifo_mmio_if.slave bus
);
   localparam int          c_PTR_W       = $clog2(DEPTH);
   localparam int          c_CNT_W       = $clog2(DEPTH + 1);
   localparam logic [63:0] c_STATUS_ADDR = BASE_ADDR + 64'd8;
   localparam logic [63:0] c_CTRL_ADDR   = BASE_ADDR + 64'd16;

   logic [7:0]         r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               r_tx_en;

   logic              w_data_sel;
   logic              w_status_sel;
   logic              w_ctrl_sel;
   logic              w_full;
   logic              w_empty;
   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic              w_stall;
   logic              w_ctrl_wr;
   logic              w_flush;
   logic [DATA_W-1:0] w_rdata;

   // Only the low byte lane carries information into this block.
   wire w_unused_data = ^bus.i_data[DATA_W-1:8];

   assign w_data_sel   = (bus.address == BASE_ADDR);
   assign w_status_sel = (bus.address == c_STATUS_ADDR);
   assign w_ctrl_sel   = (bus.address == c_CTRL_ADDR);

   assign w_full    = (r_count == c_CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_valid   = !w_empty && r_tx_en;
   assign w_pop     = w_valid && bus.ready;
   // A pop in the same cycle frees the slot, so a full FIFO need not stall.
   assign w_stall   = bus.i_wen && w_data_sel && w_full && !w_pop;
   assign w_push    = bus.i_wen && w_data_sel && !w_stall;
   assign w_ctrl_wr = bus.i_wen && w_ctrl_sel;
   assign w_flush   = w_ctrl_wr && bus.i_data[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_tx_en  <= 1'b1;
      end else begin
         if (w_ctrl_wr) begin
            r_tx_en <= bus.i_data[1];
         end
         // Flush wins over a concurrent pop; the popped byte is still consumed.
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.i_data[7:0];
      end
   end

   always_comb begin
      w_rdata = '0;
      if (bus.i_ren) begin
         if (w_status_sel) begin
            w_rdata[16 +: c_CNT_W] = r_count;
            w_rdata[1]             = w_full;
            w_rdata[0]             = w_empty;
         end else if (w_ctrl_sel) begin
            w_rdata[1] = r_tx_en;
         end
      end
   end

   assign bus.o_rdata       = w_rdata;
   assign bus.stall         = w_stall;
   assign bus.valid         = w_valid;
   assign bus.uart_out_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
endmodule
`default_nettype wire
